// File: rtl/audio_pkg.sv
// Shared types and constants for the audio record/playback transport path.
package audio_pkg;

  localparam int ADDR_W = 18;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam int SPEED_MIN = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector:
// one single-cycle pulse per key press, however long the key is held.
module key_sync_edge (
  input  logic AUD_BCLK,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge AUD_BCLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      // p0/p1: metastability settling; p2: previous level for edge detect
      sync_p0 <= key;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      pulse   <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/audio_transport_ctrl.sv
// Record/play/idle transport FSM driving the codec control word, with
// recording-length tracking and a saturating playback speed register.
module audio_transport_ctrl
  import audio_pkg::*;
#(
  parameter int ADDR_W    = audio_pkg::ADDR_W,
  parameter int SPEED_MAX = 8
) (
  input  logic              AUD_BCLK,
  input  logic              rst_n,
  input  logic              key_record,
  input  logic              key_play,
  input  logic              key_stop,
  input  logic              key_up,
  input  logic              key_down,
  input  logic [ADDR_W-1:0] address,
  output logic              stop,
  output logic              record,
  output logic              fast,
  output logic [3:0]        rate,
  output logic [ADDR_W-1:0] rec_len,
  output logic [1:0]        state
);

  logic p_record, p_play, p_stop, p_up, p_down;

  key_sync_edge u_key_record (.AUD_BCLK(AUD_BCLK), .rst_n(rst_n), .key(key_record), .pulse(p_record));
  key_sync_edge u_key_play   (.AUD_BCLK(AUD_BCLK), .rst_n(rst_n), .key(key_play),   .pulse(p_play));
  key_sync_edge u_key_stop   (.AUD_BCLK(AUD_BCLK), .rst_n(rst_n), .key(key_stop),   .pulse(p_stop));
  key_sync_edge u_key_up     (.AUD_BCLK(AUD_BCLK), .rst_n(rst_n), .key(key_up),     .pulse(p_up));
  key_sync_edge u_key_down   (.AUD_BCLK(AUD_BCLK), .rst_n(rst_n), .key(key_down),   .pulse(p_down));

  state_e            state_q, state_d;
  logic [3:0]        spd_q, spd_d;
  logic [ADDR_W-1:0] rec_len_d;

  // Saturating speed step; simultaneous up and down cancel out.
  function automatic logic [3:0] spd_step(input logic [3:0] cur, input logic up, input logic dn);
    logic [3:0] nxt;
    nxt = cur;
    if (up && !dn && int'(cur) < SPEED_MAX) begin
      nxt = cur + 4'd1;
    end else if (dn && !up && int'(cur) > SPEED_MIN) begin
      nxt = cur - 4'd1;
    end
    return nxt;
  endfunction

  always_comb begin
    state_d   = state_q;
    rec_len_d = rec_len;
    spd_d     = spd_step(spd_q, p_up, p_down);
    unique case (state_q)
      ST_IDLE: begin
        if (p_stop) begin
          state_d = ST_IDLE;
        end else if (p_record) begin
          state_d = ST_REC;
        end else if (p_play && rec_len != '0) begin
          state_d = ST_PLAY;
        end
      end
      ST_REC: begin
        // On memory full the address is all-ones, so capturing it covers both exits.
        if (p_stop || address == '1) begin
          state_d   = ST_IDLE;
          rec_len_d = address;
        end
      end
      ST_PLAY: begin
        if (p_stop || address >= rec_len) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AUD_BCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      spd_q   <= 4'(SPEED_MIN);
      rec_len <= '0;
      stop    <= 1'b1;
      record  <= 1'b0;
      fast    <= 1'b0;
      rate    <= 4'(SPEED_MIN);
    end else begin
      state_q <= state_d;
      spd_q   <= spd_d;
      rec_len <= rec_len_d;
      // Control word is registered from next-state so it lines up with state.
      stop    <= (state_d == ST_IDLE);
      record  <= (state_d == ST_REC);
      fast    <= (state_d != ST_REC) && (int'(spd_d) > SPEED_MIN);
      rate    <= (state_d == ST_REC) ? 4'(SPEED_MIN) : spd_d;
    end
  end

  assign state = state_q;

endmodule

// File: doc/audio_transport_ctrl.md
# audio_transport_ctrl

Transport controller for the audio record/playback path. Turns user key presses into the codec control word (`stop`, `record`, `fast`, `rate`) and runs the record/play/idle state machine. Tracks the length of the last recording and ends playback when the codec address reaches it. Sits between the key/UI logic and the codec, clocked in the codec's bit-clock domain.

## Interface
- `ADDR_W`, default 18: SRAM sample address width, matching the codec address.
- `SPEED_MAX`, default 8: maximum playback speed factor; must be ≤ 15.
- `AUD_BCLK`  in  1: audio bit clock; all state is registered on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `key_record`, `key_play`, `key_stop`, `key_up`, `key_down`  in  1 each: asynchronous active-high key levels, already debounced upstream.
- `address`  in  ADDR_W: current codec sample address.
- `stop`  out  1: codec stop/clear.
- `record`  out  1: codec record mode.
- `fast`  out  1: codec fast-play enable.
- `rate`  out  4: codec address step in fast play.
- `rec_len`  out  ADDR_W: end address of the last completed recording.
- `state`  out  2: current state (IDLE=0, REC=1, PLAY=2).

## Operation
- **Key conditioning.** Each key passes through a 2-flop synchronizer and then a rising-edge detector. This produces a 1-cycle pulse per press. A held key produces exactly one pulse.
- **Priority among pulses in the same cycle.** `stop` > `record` > `play`. Speed keys are evaluated independently of transport keys.
- **IDLE.** Drives `stop=1`, `record=0`.
  - Record pulse → REC.
  - Play pulse → PLAY only if `rec_len != 0`; otherwise stay in IDLE.
  - Stop pulse → stay in IDLE.
- **REC.** Drives `stop=0`, `record=1`.
  - Stop pulse → IDLE, and `rec_len <= address`.
  - `address == all-ones` (memory full) → IDLE, and `rec_len <= all-ones`.
  - If both happen in the same cycle, the result is identical.
  - Record and play pulses are ignored.
- **PLAY.** Drives `stop=0`, `record=0`.
  - Stop pulse → IDLE.
  - `address >= rec_len` (unsigned compare) → IDLE. The `>=` catches overshoot when stepping by `rate`.
  - Record and play pulses are ignored.
  - `rec_len` is unchanged.
- **Guaranteed codec clear.** IDLE always lasts at least 1 cycle with `stop=1`, so the codec address is cleared before every REC or PLAY.
- **Speed register** `spd`, range 1..SPEED_MAX:
  - Up pulse increments and saturates at SPEED_MAX.
  - Down pulse decrements and saturates at 1.
  - Simultaneous up and down: no change.
  - Speed keys are accepted in every state, and take effect mid-play.
- **Speed outputs.** `rate = spd`; `fast = (spd > 1)`.
  - Both are forced to `rate=1`, `fast=0` while in REC. `spd` itself is retained.

## Timing
- **Reset values:** `state`=IDLE, `stop=1`, `record=0`, `fast=0`, `rate=1`, `rec_len=0`, `spd=1`. Synchronizer and edge-detector flops are cleared.
- **Registered outputs.** All outputs come directly from flops; there is no combinational path from any input to any output.
- **Key latency.** A key that is high at rising edge n causes its pulse at edge n+2. The state and outputs update at edge n+3.
- **Address-based transitions** (end of playback, memory full) take effect on the edge after the condition is sampled: 1-cycle latency.
- **Reset mid-operation.** Asserting reset mid-REC returns to IDLE with `rec_len=0`; the partial recording is lost.
- **No handshake with the codec.** The codec samples the control levels on the same AUD_BCLK.

## Structure
- **Shared package `audio_pkg`** holds:
  - the state enum (IDLE/REC/PLAY),
  - `ADDR_W`,
  - `ADDR_MAX` (all-ones),
  - `SPEED_MIN=1`.
- **Sub-module `key_sync_edge`**: 2-flop synchronizer plus rising-edge pulse. It takes `AUD_BCLK` and `rst_n`, and is instantiated 5 times.
- **Top module** contains the FSM, the speed register, the `rec_len` register and the output register.

## Test plan
- **Reset, then record and stop.** Reset, press record, ramp `address` 0→1000, press stop → `record` goes 1 then 0, `stop` returns to 1, `rec_len=1000`, `state=IDLE`.
- **Play to end.** With `rec_len=1000`, press play, ramp `address` by 3 from 0 → IDLE on the cycle after `address=1002` is sampled.
- **Memory full.** Record, drive `address=18'h3FFFF` → IDLE, `rec_len=18'h3FFFF`.
- **Speed saturation.** Press up 10 times → `rate=8`, `fast=1`. Press down 10 times → `rate=1`, `fast=0`. Press up and down together → unchanged. While in REC, `rate=1`, `fast=0` regardless of `spd`.
- **Empty play and simultaneous keys.** Play with `rec_len=0` → stays in IDLE. In IDLE, record and play pressed in the same cycle → REC. In PLAY, stop and record pressed in the same cycle → IDLE.
- **Key hold and latency.** Hold record high for 50 cycles → exactly one transition, on the 3rd edge after the first sample. Assert `rst_n` low mid-REC → all outputs return to reset values immediately (asynchronously).
